// File: rtl/store_data_pack.sv
// store_data_pack: packs SB/SH/SW data into lane-replicated words, buffers them in a 2-entry FIFO, and pulses a fault on misaligned or illegal stores
module store_data_pack #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              i_flush,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [1:0]        i_size,
  input  logic [31:0]       i_data,
  output logic              o_mem_valid,
  input  logic              i_mem_ready,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [31:0]       o_mem_wdata,
  output logic [3:0]        o_mem_be,
  output logic              o_fault,
  output logic [ADDR_W-1:0] o_fault_addr,
  output logic [CNT_W-1:0]  o_store_count
);
  logic [ADDR_W-1:0] f_addr [2];
  logic [31:0]       f_data [2];
  logic [3:0]        f_be   [2];
  logic              rd, wr;
  logic [1:0]        cnt;
  logic              bad, acc, push, pop;
  logic [31:0]       wdata;
  logic [3:0]        be;
  always_comb begin
    bad   = (i_size == 2'b11) || (i_size == 2'b01 && i_addr[0]) || (i_size == 2'b10 && i_addr[1:0] != 2'b00);
    wdata = i_size == 2'b00 ? {4{i_data[7:0]}} : i_size == 2'b01 ? {2{i_data[15:0]}} : i_data;
    be    = i_size == 2'b00 ? 4'b0001 << i_addr[1:0] : i_size == 2'b01 ? 4'b0011 << {i_addr[1], 1'b0} : 4'b1111;
  end
  assign o_ready     = !cnt[1];
  assign o_mem_valid = cnt != 2'd0;
  assign o_mem_addr  = f_addr[rd];
  assign o_mem_wdata = f_data[rd];
  assign o_mem_be    = f_be[rd];
  // a transfer coinciding with a flush is discarded outright, fault included
  assign acc  = i_valid & o_ready & !i_flush;
  assign push = acc & !bad;
  assign pop  = o_mem_valid & i_mem_ready;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      f_addr[0]     <= '0;
      f_addr[1]     <= '0;
      f_data[0]     <= '0;
      f_data[1]     <= '0;
      f_be[0]       <= '0;
      f_be[1]       <= '0;
      rd            <= 1'b0;
      wr            <= 1'b0;
      cnt           <= 2'd0;
      o_fault       <= 1'b0;
      o_fault_addr  <= '0;
      o_store_count <= '0;
    end else begin
      o_fault <= acc & bad;
      if (acc & bad) o_fault_addr <= i_addr;
      if (push) o_store_count <= o_store_count + 1'b1;
      if (i_flush) begin
        rd  <= 1'b0;
        wr  <= 1'b0;
        cnt <= 2'd0;
      end else begin
        if (push) begin
          f_addr[wr] <= {i_addr[ADDR_W-1:2], 2'b00};
          f_data[wr] <= wdata;
          f_be[wr]   <= be;
          wr         <= !wr;
        end
        if (pop) rd <= !rd;
        cnt <= cnt + 2'(push) - 2'(pop);
      end
    end
  end
endmodule
